// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration slave: FSM encoding,
// instruction word layout and transfer-length codes.
package spi_cfg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INSTR = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Transfer-length codes carried in instruction bits 14:13
  localparam logic [1:0] W_1B     = 2'b00;
  localparam logic [1:0] W_2B     = 2'b01;
  localparam logic [1:0] W_3B     = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

  localparam int        ADDR_W     = 13;
  localparam logic [3:0] INSTR_LAST = 4'd15;
  localparam logic [2:0] BYTE_LAST  = 3'd7;

  // Instruction word, MSB first on the wire: bit15 R/nW, 14:13 W, 12:0 address
  typedef struct packed {
    logic              rnw;
    logic [1:0]        wcode;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // True when the byte just completed is the last one the W code allows
  function automatic logic last_byte(input logic [1:0] wcode, input logic [1:0] byte_cnt);
    case (wcode)
      W_1B:     return byte_cnt == 2'd0;
      W_2B:     return byte_cnt == 2'd1;
      W_3B:     return byte_cnt == 2'd2;
      W_STREAM: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta, prev;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 slave giving a master read/write access to a small bank of
// 8-bit configuration registers. Register 0 reads back as CHIP_ID.
module spi_cfg_slave
  import spi_cfg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] CHIP_ID  = 8'h30
) (
  input  logic                    fpga_0_clk_1_sys_clk_pin,
  input  logic                    fpga_0_rst_1_sys_rst_pin,
  input  logic                    spi_sck_i,
  input  logic                    spi_ss_n_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic                    spi_miso_oe_o,
  output logic                    reg_wr_stb_o,
  output logic [ADDR_W-1:0]       reg_wr_addr_o,
  output logic [7:0]              reg_wr_data_o,
  output logic [8*NUM_REGS-1:0]   regs_o
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic clk, rst;
  assign clk = fpga_0_clk_1_sys_clk_pin;
  assign rst = fpga_0_rst_1_sys_rst_pin;

  // Lane 0 = SCK, 1 = SS_n, 2 = MOSI. SS resets low so a frame already in
  // progress at reset release is not mistaken for a new one.
  logic [2:0] sync_q, sync_rise, sync_fall;
  spi_sync_edge u_sync [2:0] (
    .clk  (clk),
    .rst  (rst),
    .d    ({spi_mosi_i, spi_ss_n_i, spi_sck_i}),
    .q    (sync_q),
    .rise (sync_rise),
    .fall (sync_fall)
  );

  logic ss_hi, mosi, sck_rise, sck_fall, ss_fall;
  assign ss_hi    = sync_q[1];
  assign mosi     = sync_q[2];
  assign sck_rise = sync_rise[0] & ~ss_hi;
  assign sck_fall = sync_fall[0] & ~ss_hi;
  assign ss_fall  = sync_fall[1];

  logic unused_sync;
  assign unused_sync = ^{sync_q[0], sync_rise[2:1], sync_fall[2]};

  logic [1:0]        state;
  logic [3:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [14:0]       instr_sr;
  logic [6:0]        rx_sr;
  logic [7:0]        tx_sr;
  logic              miso_q;
  logic              rnw;
  logic [1:0]        wcode;
  logic [ADDR_W-1:0] addr;
  logic [NUM_REGS-1:0][7:0] regs;

  instr_t            ins;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_nxt;
  logic              byte_done, wr_commit, wr_hit;

  assign ins       = instr_t'({instr_sr, mosi});
  assign rx_byte   = {rx_sr, mosi};
  assign addr_nxt  = addr + 1'b1;
  assign byte_done = (state == ST_DATA) && sck_rise && (bit_cnt[2:0] == BYTE_LAST);
  assign wr_commit = byte_done && !rnw;
  assign wr_hit    = (addr != '0) && (addr < ADDR_W'(NUM_REGS));

  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a);
    if (a == '0)                         return CHIP_ID;
    else if (a < ADDR_W'(NUM_REGS))      return regs[a[AW-1:0]];
    else                                 return 8'h00;
  endfunction

  // Frame sequencing, shift registers and write strobe; SS high wins over any edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      instr_sr      <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      miso_q        <= 1'b0;
      rnw           <= 1'b0;
      wcode         <= '0;
      addr          <= '0;
      reg_wr_stb_o  <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
    end else begin
      reg_wr_stb_o <= 1'b0;
      if (ss_hi) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        instr_sr <= '0;
        rx_sr    <= '0;
        tx_sr    <= '0;
        miso_q   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (ss_fall) begin
            state   <= ST_INSTR;
            bit_cnt <= '0;
          end
          ST_INSTR: if (sck_rise) begin
            instr_sr <= {instr_sr[13:0], mosi};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == INSTR_LAST) begin
              state    <= ST_DATA;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              rnw      <= ins.rnw;
              wcode    <= ins.wcode;
              addr     <= ins.addr;
              if (ins.rnw) tx_sr <= rd_byte(ins.addr);
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              rx_sr   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (byte_done) begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + 1'b1;
                addr     <= addr_nxt;
                if (rnw) tx_sr <= rd_byte(addr_nxt);
                else begin
                  reg_wr_stb_o  <= 1'b1;
                  reg_wr_addr_o <= addr;
                  reg_wr_data_o <= rx_byte;
                end
                if (last_byte(wcode, byte_cnt)) state <= ST_DRAIN;
              end
            end
            if (sck_fall && rnw) begin
              miso_q <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
          end
          default: ;  // DRAIN: every SCK edge is ignored until SS rises
        endcase
      end
    end
  end

  // Register file update, in the same cycle the strobe goes out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs <= '0;
    else if (wr_commit && wr_hit) regs[addr[AW-1:0]] <= rx_byte;
  end

  assign regs_o        = regs;
  assign spi_miso_oe_o = (state == ST_DATA) && rnw;
  assign spi_miso_o    = spi_miso_oe_o & miso_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Bench for spi_cfg_slave: a bit-level SPI master, a transaction-level model
// of the register bank, directed scenarios and a randomized frame loop.
module tb_spi_cfg_slave;
  import spi_cfg_pkg::*;

  localparam int         NR   = 16;
  localparam logic [7:0] CID  = 8'h30;
  localparam int         HALF = 5;   // SCK half period in sys clocks

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, stb;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [8*NR-1:0] regs_o;

  always #5 clk = ~clk;

  spi_cfg_slave #(.NUM_REGS(NR), .CHIP_ID(CID)) dut (
    .fpga_0_clk_1_sys_clk_pin (clk),
    .fpga_0_rst_1_sys_rst_pin (rst),
    .spi_sck_i                (sck),
    .spi_ss_n_i               (ss_n),
    .spi_mosi_i               (mosi),
    .spi_miso_o               (miso),
    .spi_miso_oe_o            (miso_oe),
    .reg_wr_stb_o             (stb),
    .reg_wr_addr_o            (wr_addr),
    .reg_wr_data_o            (wr_data),
    .regs_o                   (regs_o)
  );

  int checks = 0, failures = 0;
  int cyc = 0, stb_total = 0, stb_cyc = 0, rise_cyc = 0, oe_hi = 0;
  logic [8*NR-1:0] mflat = '0;
  logic [20:0]     exp_wq[$];
  logic [20:0]     e;
  logic [7:0]      tx_data[8], rx_data[8], exp_rd[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input logic [12:0] a);
    if (a == 13'd0) return CID;
    if (a < 13'(NR)) return mflat[8*int'(a) +: 8];
    return 8'h00;
  endfunction

  // Per-cycle compare: strobes against the expected-write queue, register
  // file against the model, MISO quiet whenever it is not enabled
  always @(negedge clk) begin
    if (rst) begin
      mflat = '0;
      exp_wq.delete();
    end else begin
      if (stb) begin
        stb_total++;
        stb_cyc = cyc;
        if (exp_wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_stb: got strobe addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          e = exp_wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e[20:8]));
          chk("wr_data", 32'(wr_data), 32'(e[7:0]));
          if (e[20:8] != 13'd0 && e[20:8] < 13'(NR)) mflat[8*int'(e[20:8]) +: 8] = e[7:0];
        end
      end
      checks++;
      if (regs_o !== mflat) begin
        failures++;
        $display("FAIL regs_o: got %h expected %h", regs_o, mflat);
      end
      chk("miso_idle", 32'(miso & ~miso_oe), 32'd0);
    end
  end

  // One SCK period: set MOSI, sample MISO/OE just before the rising edge
  task automatic send_bit(input logic b, output logic s_oe, output logic s_miso);
    mosi = b;
    repeat (HALF) @(posedge clk);
    #1;
    s_oe   = miso_oe;
    s_miso = miso;
    sck = 1'b1;
    rise_cyc = cyc;
    repeat (HALF) @(posedge clk);
    #1;
    sck = 1'b0;
  endtask

  // Full frame of nbits SCK periods; expectations come from the model first
  task automatic run_frame(input logic [15:0] instr, input int nbits);
    logic rnw, b, s_oe, s_miso, e_oe, e_miso;
    logic [1:0] w;
    logic [12:0] a;
    int nfull, eff, j, k;
    rnw = instr[15];
    w   = instr[14:13];
    a   = instr[12:0];
    nfull = (nbits >= 16) ? (nbits - 16) / 8 : 0;
    eff   = (w == 2'b11) ? nfull : ((nfull < int'(w) + 1) ? nfull : int'(w) + 1);
    for (int i = 0; i < 8; i++) begin
      exp_rd[i]  = mread(a + 13'(i));
      rx_data[i] = 8'h00;
    end
    if (!rnw) for (int i = 0; i < eff; i++) exp_wq.push_back({a + 13'(i), tx_data[i]});
    oe_hi = 0;
    @(posedge clk); #1;
    ss_n = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    for (int i = 0; i < nbits; i++) begin
      j = i - 16;
      k = (j >= 0) ? j / 8 : 0;
      b = (i < 16) ? instr[15-i] : tx_data[k][7 - j % 8];
      send_bit(b, s_oe, s_miso);
      if (i >= 16) begin
        e_oe   = rnw && (w == 2'b11 || k <= int'(w));
        e_miso = e_oe ? exp_rd[k][7 - j % 8] : 1'b0;
        rx_data[k][7 - j % 8] = s_miso;
      end else begin
        e_oe = 1'b0;
        e_miso = 1'b0;
      end
      chk($sformatf("miso_bit%0d", i), {30'd0, s_oe, s_miso}, {30'd0, e_oe, e_miso});
      oe_hi += int'(s_oe);
    end
    repeat (2) @(posedge clk); #1;
    ss_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("stb_missing", 32'(exp_wq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, nb, part, nbits, sel;
    logic s_oe, s_miso, rnw_r;
    logic [1:0]  w_r;
    logic [12:0] a_r;
    logic [15:0] ins;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_stb", 32'(stb), 0);
    chk("rst_oe", 32'(miso_oe), 0);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_regs_or", 32'(|regs_o), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Single-byte write to register 3, with strobe latency pinned
    tx_data[0] = 8'hA5;
    s0 = stb_total;
    run_frame(16'h0003, 24);
    chk("t1_stb_count", 32'(stb_total - s0), 1);
    chk("t1_reg3", 32'(regs_o[31:24]), 32'hA5);
    chk("t1_latency", 32'(stb_cyc - rise_cyc), 3);

    // Read of the chip ID, with two extra bytes' worth of clocks after it
    run_frame(16'h8000, 32);
    chk("t2_chip_id", 32'(rx_data[0]), 32'h30);
    chk("t2_oe_cycles", 32'(oe_hi), 8);

    // Streaming write across the end of the register file
    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    s0 = stb_total;
    run_frame(16'h600E, 40);
    chk("t3_stb_count", 32'(stb_total - s0), 3);
    chk("t3_reg_e", 32'(regs_o[8*14 +: 8]), 32'h11);
    chk("t3_reg_f", 32'(regs_o[8*15 +: 8]), 32'h22);
    chk("t3_last_addr", 32'(wr_addr), 32'h010);
    chk("t3_last_data", 32'(wr_data), 32'h33);

    // One-byte write followed by a byte that must be drained
    tx_data[0] = 8'h5A; tx_data[1] = 8'h77;
    s0 = stb_total;
    run_frame(16'h0005, 32);
    chk("t4_stb_count", 32'(stb_total - s0), 1);
    chk("t4_reg5", 32'(regs_o[8*5 +: 8]), 32'h5A);

    // SS raised 5 bits into the data byte, then a normal frame
    tx_data[0] = 8'h99;
    s0 = stb_total;
    run_frame(16'h0006, 21);
    chk("t5_stb_count", 32'(stb_total - s0), 0);
    chk("t5_idle", 32'(dut.state), 32'(ST_IDLE));
    tx_data[0] = 8'h3C;
    run_frame(16'h0006, 24);
    chk("t5_reg6", 32'(regs_o[8*6 +: 8]), 32'h3C);

    // Streaming read back of registers 3..5
    run_frame(16'hE003, 40);
    chk("t6_rd3", 32'(rx_data[0]), 32'hA5);
    chk("t6_rd4", 32'(rx_data[1]), 32'h00);
    chk("t6_rd5", 32'(rx_data[2]), 32'h5A);

    // Reset pulsed in the middle of a read data phase
    ins = 16'hE003;
    @(posedge clk); #1;
    ss_n = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    for (int i = 0; i < 19; i++) send_bit((i < 16) ? ins[15-i] : 1'b0, s_oe, s_miso);
    chk("t7_oe_before_rst", 32'(miso_oe), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t7_oe_in_rst", 32'(miso_oe), 0);
    chk("t7_regs_zero", 32'(|regs_o), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    s0 = stb_total;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, s_oe, s_miso);
      chk("t7_oe_after_rst", 32'(s_oe), 0);
    end
    repeat (2) @(posedge clk); #1;
    ss_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("t7_no_stb", 32'(stb_total - s0), 0);
    run_frame(16'h8003, 24);
    chk("t7_rd3_cleared", 32'(rx_data[0]), 32'h00);
    tx_data[0] = 8'h42;
    run_frame(16'h0003, 24);
    chk("t7_reg3_new", 32'(regs_o[31:24]), 32'h42);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      rnw_r = 1'($urandom_range(0, 1));
      w_r   = 2'($urandom_range(0, 3));
      sel   = int'($urandom_range(0, 9));
      if (sel == 0)      a_r = 13'h1FFE + 13'($urandom_range(0, 1));
      else if (sel == 1) a_r = 13'($urandom_range(16, 8191));
      else               a_r = 13'($urandom_range(0, NR + 1));
      nb    = int'($urandom_range(0, 5));
      part  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      nbits = 16 + 8 * nb + part;
      if ($urandom_range(0, 9) == 0) nbits = int'($urandom_range(1, 15));
      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
      run_frame({rnw_r, w_r, a_r}, nbits);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cfg_slave.md
SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit config registers (power of 2, 2..256).
REQ-002 SHALL have parameter CHIP_ID, default 8'h30, read-only value of register 0x000.
REQ-003 SHALL have port fpga_0_clk_1_sys_clk_pin, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port fpga_0_rst_1_sys_rst_pin, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port spi_sck_i, input, 1, SPI clock from the master (mode 0, CPOL=0, CPHA=0).
REQ-006 SHALL have port spi_ss_n_i, input, 1, active-low slave select.
REQ-007 SHALL have port spi_mosi_i, input, 1, master-to-slave data, MSB first.
REQ-008 SHALL have port spi_miso_o, output, 1, slave-to-master data, MSB first.
REQ-009 SHALL have port spi_miso_oe_o, output, 1, high while a read data phase is driving spi_miso_o.
REQ-010 SHALL have port reg_wr_stb_o, output, 1, one-cycle pulse per committed register write.
REQ-011 SHALL have port reg_wr_addr_o, output, 13, address of the committed write.
REQ-012 SHALL have port reg_wr_data_o, output, 8, data of the committed write.
REQ-013 SHALL have port regs_o, output, 8*NUM_REGS, flat register file; register n at bits [8n+7:8n].

Function
REQ-014 SHALL pass spi_sck_i, spi_ss_n_i and spi_mosi_i through 2-flop synchronizers; operation is guaranteed for sys clock >= 8x SCK.
REQ-015 SHALL detect SCK rising and falling edges from the synchronized SCK only while synchronized SS is low.
REQ-016 SHALL frame each transfer as a 16-bit instruction followed by data bytes: bit15 R/nW (1 = read), bits14:13 W (00=1, 01=2, 10=3 bytes, 11=stream until SS high), bits12:0 start address.
REQ-017 SHALL use FSM states IDLE, INSTR, DATA and DRAIN: IDLE->INSTR on SS falling; INSTR->DATA after the 16th SCK rising edge; DATA->DRAIN after the W+1th byte (W != 11); any state->IDLE on SS high.
REQ-018 SHALL sample MOSI on SCK rising edges and shift MISO on SCK falling edges.
REQ-019 SHALL increment the address by one after each data byte, wrapping from 0x1FFF to 0x0000.
REQ-020 SHALL, on a write, assert reg_wr_stb_o for one cycle, exactly 1 sys clock after the 8th data-bit rising edge is detected, and update the register in that same cycle.
REQ-021 SHALL ignore writes to address 0x000 and to addresses >= NUM_REGS for the register file, while still pulsing reg_wr_stb_o for them.
REQ-022 SHALL, on a read, load the byte on the rising edge that completes the instruction or the previous byte, and present its bit7 on spi_miso_o at the following SCK falling edge.
REQ-023 SHALL return CHIP_ID for address 0x000 and 0x00 for addresses >= NUM_REGS.
REQ-024 SHALL drive spi_miso_o low and spi_miso_oe_o low outside the read DATA state.
REQ-025 SHALL ignore all SCK edges in DRAIN.
REQ-026 SHALL discard any partial instruction or partial byte when SS goes high; bytes already committed stay committed.
REQ-027 SHALL give precedence to SS deassertion over an SCK edge detected in the same cycle; that edge is dropped.

Reset
REQ-028 SHALL, on reset, put the FSM in IDLE, clear all shift registers and counters, drive spi_miso_o=0, spi_miso_oe_o=0 and reg_wr_stb_o=0, drive reg_wr_addr_o=0 and reg_wr_data_o=0, and set all registers to 0x00 (address 0x000 still reads CHIP_ID).
REQ-029 SHALL, when reset is asserted mid-transfer, abort immediately, and then wait for an SS rising edge before accepting a new frame.

Structure
REQ-030 SHALL place the FSM state encoding, the instruction field positions and the W-code constants in the shared package spi_cfg_pkg.
REQ-031 SHALL use one sub-module, spi_sync_edge, for synchronization and edge detection, instantiated once per input.

Verification
REQ-032 Bench SHALL check: write 0x0A5 to addr 0x003 (instr 0x0003, W=00) -> one reg_wr_stb_o, regs_o[31:24]=0xA5.
REQ-033 Bench SHALL check: read addr 0x000 (instr 0x8000) -> MISO returns 0x30 with spi_miso_oe_o high for 8 SCK.
REQ-034 Bench SHALL check: streaming write W=11 from addr 0x00E with bytes 11,22,33 at NUM_REGS=16 -> regs 0xE=11 and 0xF=22; write to 0x010 is strobed but not stored.
REQ-035 Bench SHALL check: W=00 write followed by a 2nd byte -> the 2nd byte is ignored (DRAIN) and no second strobe occurs.
REQ-036 Bench SHALL check: SS raised after 5 bits of a data byte -> no strobe, FSM in IDLE, and the next frame works.
REQ-037 Bench SHALL check: reset pulsed mid-read -> spi_miso_oe_o=0 within 1 cycle and all registers are 0x00.
